// File: rtl/seg_scan_pkg.sv
// Shared types and limits for the seven-segment scan controller.
package seg_scan_pkg;
  localparam int MAX_DIGITS = 8;

  typedef logic [2:0] digit_idx_t;
  typedef logic [3:0] digit_val_t;
endpackage

// File: rtl/refresh_tick_gen.sv
// Digit-slot prescaler: one-cycle tick every DIV enabled clocks, frozen while en=0.
module refresh_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Down-counter: LOAD here is the first cycle of a slot, zero is the last one.
  assign tick = en && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LOAD;
    end else if (en) begin
      count <= (count == '0) ? LOAD : count - 1'b1;
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner feeding the seven-segment decoder.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] digit_en,
  output logic [3:0] num,
  output logic [2:0] sel,
  output logic       blank,
  output logic       frame_done
);
  localparam digit_idx_t LAST = digit_idx_t'(NUM_DIGITS - 1);
  localparam logic [3:0] NUM_DIGITS_W = 4'(NUM_DIGITS);

  logic       tick;
  logic       lzb_sel;
  digit_val_t regs [MAX_DIGITS];

  refresh_tick_gen #(.DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && (sel == LAST);
      if (tick) begin
        sel <= (sel == LAST) ? '0 : sel + 1'b1;
      end
    end
  end

  // Entries at or above NUM_DIGITS are never written and stay at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_DIGITS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && ({1'b0, wr_addr} < NUM_DIGITS_W)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign num = regs[sel];

`ifdef SEG_SCAN_LZB_EN
  logic [MAX_DIGITS-1:0] lzb;
  logic                  zero_tail;

  // A digit is leading-zero only if it and every more significant digit are zero.
  always_comb begin
    lzb       = '0;
    zero_tail = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < NUM_DIGITS) begin
        zero_tail = zero_tail & (regs[i] == 4'h0);
        lzb[i]    = zero_tail;
      end
    end
  end

  assign lzb_sel = lzb[sel];
`else
  assign lzb_sel = 1'b0;
`endif

  assign blank = !en || !digit_en[sel] || lzb_sel;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (8-digit and 6-digit instances, DIV=4).
module tb_seg_scan_ctrl;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] digit_en;
  logic [3:0] num, num6;
  logic [2:0] sel, sel6;
  logic       blank, blank6;
  logic       frame_done, frame_done6;

  int n_checks = 0;
  int n_errors = 0;

  seg_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .digit_en(digit_en), .num(num), .sel(sel),
    .blank(blank), .frame_done(frame_done)
  );

  seg_scan_ctrl #(.NUM_DIGITS(6), .REFRESH_DIV(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .digit_en(digit_en), .num(num6), .sel(sel6),
    .blank(blank6), .frame_done(frame_done6)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    wr_en    = 1'b0;
    digit_en = 8'hFF;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; digit_en = 8'hFF;
    #1;
    check_eq("rst_sel", sel, 0);
    check_eq("rst_num", num, 0);
    check_eq("rst_fd", frame_done, 0);
    check_eq("rst_blank_en0", blank, 1);
    en = 1'b1; #1;
    check_eq("rst_blank_en1", blank, 0);
    digit_en = 8'hFE; #1;
    check_eq("rst_blank_mask", blank, 1);
    step(1);

    // Free-running scan, 8 and 6 digits; all-zero file exercises LZB too.
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      s = (k / 4) % 8;
      check_eq("scan_sel", sel, s);
      check_eq("scan_fd", frame_done, (k == 32));
      check_eq("scan_blank", blank, (LZB && s != 0));
      check_eq("scan_num", num, 0);
      check_eq("scan_sel6", sel6, (k / 4) % 6);
      check_eq("scan_fd6", frame_done6, (k == 24));
    end

    // Register file contents follow sel; addr 6/7 ignored by the 6-digit instance.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1);
      step(1);
    end
    wr_en = 1'b0;
    check_eq("wr_num0", num, 1);
    en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      check_eq("rd_num", num, ((k / 4) % 8) + 1);
      check_eq("rd_num6", num6, ((k / 4) % 6) + 1);
      check_eq("rd_blank", blank, 0);
    end
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hA; #1;
    check_eq("wr_cur_before", num, 1);
    step(1);
    check_eq("wr_cur_after", num, 4'hA);
    wr_en = 1'b0;
    step(2);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'hB;
    step(1);
    check_eq("wr_tick_sel", sel, 1);
    check_eq("wr_tick_num", num, 4'hB);
    wr_en = 1'b0;

    // Reset in the middle of a scan.
    rst_n = 1'b0; #1;
    check_eq("mid_rst_sel", sel, 0);
    check_eq("mid_rst_num", num, 0);
    check_eq("mid_rst_fd", frame_done, 0);
    check_eq("mid_rst_blank", blank, 0);
    en = 1'b0; #1;
    check_eq("mid_rst_blank_en0", blank, 1);
    en = 1'b1; digit_en = 8'hFE; #1;
    check_eq("mid_rst_blank_mask", blank, 1);
    digit_en = 8'hFF;
    step(1);

    // Freeze at sel=3 and resume from the remaining prescale count.
    do_reset();
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 4'h5;
    step(1);
    wr_en = 1'b0;
    en = 1'b1;
    step(13);
    check_eq("frz_sel_pre", sel, 3);
    en = 1'b0; #1;
    check_eq("frz_blank_now", blank, 1);
    step(20);
    check_eq("frz_sel", sel, 3);
    check_eq("frz_sel6", sel6, 3);
    check_eq("frz_blank", blank, 1);
    check_eq("frz_fd", frame_done, 0);
    en = 1'b1;
    step(2);
    check_eq("res_sel_hold", sel, 3);
    digit_en = 8'hF7; #1;
    check_eq("res_blank_mask", blank, 1);
    digit_en = 8'hFF; #1;
    check_eq("res_blank_clr", blank, 0);
    step(1);
    check_eq("res_sel_step", sel, 4);

    // Digits {0,0,0,0,0,1,2,3}: leading zeros blanked on sel 3..7 when LZB is built in.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(3 - i);
      step(1);
    end
    wr_en = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      s = (k / 4) % 8;
      check_eq("lzb_sel", sel, s);
      check_eq("lzb_num", num, (s < 3) ? (3 - s) : 0);
      check_eq("lzb_blank", blank, (LZB && s >= 3));
      check_eq("lzb_blank6", blank6, (LZB && ((k / 4) % 6) >= 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
